fifo_pixel_streamer: RTL and testbench

- Downstream drain stage for FIFO_module: pops 16-bit pixels from the BRAM FIFO read port and presents them as a valid/ready stream to the next datapath element.
- Hides the FIFO's 1-cycle read latency with a 3-entry output buffer, so the stream runs at one pixel per clock under continuous ready.
- Tags each pixel with a column index and end-of-line flag, and latches FIFO read errors.

---
 rtl/ippro_stream_pkg.sv | 11 +
 rtl/stream_skid_buf.sv | 64 ++++++
 rtl/fifo_pixel_streamer.sv | 69 ++++++
 tb/tb_fifo_pixel_streamer.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ippro_stream_pkg.sv
// Shared pixel-stream definitions: pixel width, default line geometry, buffer depth.
package ippro_stream_pkg;

    localparam int PIXEL_W        = 16;
    localparam int DEF_LINE_WIDTH = 512;
    localparam int DEF_COL_W      = 10;
    localparam int BUF_DEPTH      = 3;

    typedef logic [PIXEL_W-1:0] pixel_t;

endpackage

// File: rtl/stream_skid_buf.sv
// 3-entry synchronous buffer; push lands on the edge, head/occupancy are registered.
// Pop is ignored when empty; a push into a full buffer without a pop is an upstream bug.
module stream_skid_buf
    import ippro_stream_pkg::*;
#(
    parameter int W = PIXEL_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         valid,
    output logic [1:0]   occupancy
);

    logic [W-1:0] mem [BUF_DEPTH];
    logic [1:0]   rd_ptr;
    logic [1:0]   wr_ptr;
    logic [1:0]   count;
    logic         do_pop;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign do_pop    = pop && (count != 2'd0);
    assign head      = mem[rd_ptr];
    assign valid     = (count != 2'd0);
    assign occupancy = count;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= 2'd0;
            wr_ptr <= 2'd0;
            count  <= 2'd0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // The issuer reserves a slot before every read, so a push can never meet a full buffer.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(push && !do_pop && (count == 2'd3)));
        end
    end

endmodule

// File: rtl/fifo_pixel_streamer.sv
// Drains the BRAM FIFO into a valid/ready pixel stream tagged with column and end-of-line.
// First pixel two edges after READ_EN; reads pause once buffered + in-flight words reach 3.
module fifo_pixel_streamer
    import ippro_stream_pkg::*;
#(
    parameter int DATA_W     = PIXEL_W,
    parameter int LINE_WIDTH = DEF_LINE_WIDTH,
    parameter int COL_W      = DEF_COL_W
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              ENABLE,
    input  logic [DATA_W-1:0] FIFO_OUT,
    input  logic              EMPTY,
    input  logic              RDERR,
    output logic              READ_EN,
    output logic [DATA_W-1:0] DOUT,
    output logic              DOUT_VALID,
    input  logic              DOUT_READY,
    output logic              DOUT_EOL,
    output logic [COL_W-1:0]  COL_COUNT,
    output logic [1:0]        OCCUPANCY,
    output logic              ERR
);

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE_WIDTH - 1);

    logic              inflight;
    logic [2:0]        pending;
    logic              handshake;
    logic [DATA_W-1:0] head;

    // Slot reservation counts the word already requested, so DOUT_READY never reaches READ_EN.
    assign pending   = {1'b0, OCCUPANCY} + {2'b00, inflight};
    assign READ_EN   = ~RESET & ENABLE & ~EMPTY & (pending < 3'd3);
    assign handshake = DOUT_VALID & DOUT_READY;
    assign DOUT      = DOUT_VALID ? head : '0;
    assign DOUT_EOL  = DOUT_VALID & (COL_COUNT == LAST_COL);

    stream_skid_buf #(
        .W (DATA_W)
    ) u_buf (
        .clk       (CLK),
        .reset     (RESET),
        .push      (inflight),
        .push_data (FIFO_OUT),
        .pop       (handshake),
        .head      (head),
        .valid     (DOUT_VALID),
        .occupancy (OCCUPANCY)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            inflight  <= 1'b0;
            COL_COUNT <= '0;
            ERR       <= 1'b0;
        end else begin
            inflight <= READ_EN;
            if (handshake) begin
                COL_COUNT <= (COL_COUNT == LAST_COL) ? '0 : COL_COUNT + 1'b1;
            end
            if (RDERR) begin
                ERR <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_pixel_streamer.sv
// Bench for fifo_pixel_streamer: behavioural BRAM FIFO, in-order pixel scoreboard, scenario tasks.
module tb_fifo_pixel_streamer;
    import ippro_stream_pkg::*;

    localparam int LW = 4;
    localparam int CW = DEF_COL_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, enable, rderr, read_en, dout_valid, dout_ready, dout_eol, err;
    logic          empty = 1'b1;
    pixel_t        fifo_out = '0;
    pixel_t        dout;
    logic [CW-1:0] col_count;
    logic [1:0]    occupancy;

    logic   push_en;
    pixel_t push_data;

    pixel_t        fifo_q[$];
    pixel_t        exp_q[$];
    pixel_t        eol_q[$];
    logic [CW-1:0] col_q[$];
    int            hs_cyc[$];

    int            n_checks = 0;
    int            n_fail   = 0;
    int            delivered = 0;
    int            out_idx  = 0;
    int            cycle    = 0;
    pixel_t        last_dout;
    logic [CW-1:0] last_col;
    pixel_t        mon_exp;
    int            mon_col;

    fifo_pixel_streamer #(
        .DATA_W     (PIXEL_W),
        .LINE_WIDTH (LW),
        .COL_W      (CW)
    ) dut (
        .CLK        (clk),
        .RESET      (reset),
        .ENABLE     (enable),
        .FIFO_OUT   (fifo_out),
        .EMPTY      (empty),
        .RDERR      (rderr),
        .READ_EN    (read_en),
        .DOUT       (dout),
        .DOUT_VALID (dout_valid),
        .DOUT_READY (dout_ready),
        .DOUT_EOL   (dout_eol),
        .COL_COUNT  (col_count),
        .OCCUPANCY  (occupancy),
        .ERR        (err)
    );

    // Behavioural FIFO_module: 1-cycle read latency, registered empty flag.
    always @(posedge clk) begin
        cycle <= cycle + 1;
        if (reset) begin
            fifo_q.delete();
            fifo_out <= '0;
            empty    <= 1'b1;
        end else begin
            if (read_en && fifo_q.size() != 0) fifo_out <= fifo_q.pop_front();
            if (push_en) fifo_q.push_back(push_data);
            empty <= (fifo_q.size() == 0);
        end
    end

    // Scoreboard: every handshake must return the next pushed pixel with column = index mod LW.
    always @(negedge clk) begin
        if (!reset) begin
            n_checks++;
            if (read_en && empty) begin
                n_fail++;
                $display("FAIL read_while_empty: READ_EN=%b EMPTY=%b at cycle %0d, required no read", read_en, empty, cycle);
            end
            if (dout_valid && dout_ready) begin
                n_checks++;
                mon_col = out_idx % LW;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_pixel: got %h, required no output", dout);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (dout !== mon_exp || col_count !== CW'(mon_col) || dout_eol !== (mon_col == LW - 1)) begin
                        n_fail++;
                        $display("FAIL stream_pixel: got dout=%h col=%0d eol=%b, required dout=%h col=%0d eol=%b",
                                 dout, col_count, dout_eol, mon_exp, mon_col, (mon_col == LW - 1));
                    end
                end
                if (dout_eol) eol_q.push_back(dout);
                col_q.push_back(col_count);
                hs_cyc.push_back(cycle);
                last_dout = dout;
                last_col  = col_count;
                delivered++;
                out_idx++;
            end
        end
    end

    task automatic push_word(input pixel_t v);
        push_en   = 1'b1;
        push_data = v;
        exp_q.push_back(v);
        @(posedge clk); #1;
        push_en = 1'b0;
    endtask

    task automatic apply_reset();
        reset   = 1'b1;
        push_en = 1'b0;
        rderr   = 1'b0;
        exp_q.delete();
        eol_q.delete();
        col_q.delete();
        hs_cyc.delete();
        out_idx = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({read_en, dout, dout_valid, dout_eol, col_count, occupancy, err} !== '0) begin
            n_fail++;
            $display("FAIL reset_hold: got re=%b dout=%h v=%b eol=%b col=%0d occ=%0d err=%b, required all 0",
                     read_en, dout, dout_valid, dout_eol, col_count, occupancy, err);
        end
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({read_en, dout, dout_valid, dout_eol, col_count, occupancy, err} !== '0) begin
            n_fail++;
            $display("FAIL reset_release: got re=%b dout=%h v=%b occ=%0d err=%b, required all 0",
                     read_en, dout, dout_valid, occupancy, err);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic_drain();
        pixel_t vals [4] = '{16'd20, 16'd30, 16'd40, 16'd50};
        int d0, first_re, first_v;
        apply_reset();
        enable = 1'b1; dout_ready = 1'b1;
        d0 = delivered; first_re = -1; first_v = -1;
        for (int i = 0; i < 24; i++) begin
            if (i < 4) begin
                push_en = 1'b1; push_data = vals[i]; exp_q.push_back(vals[i]);
            end else begin
                push_en = 1'b0;
            end
            @(negedge clk);
            if (read_en && first_re < 0) first_re = cycle;
            if (dout_valid && first_v < 0) first_v = cycle;
            @(posedge clk); #1;
        end
        push_en = 1'b0;
        n_checks++;
        if (first_v - first_re !== 2) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d cycles READ_EN->DOUT_VALID, required 2", first_v - first_re);
        end
        n_checks++;
        if (delivered - d0 !== 4) begin
            n_fail++;
            $display("FAIL basic_count: got %0d pixels, required 4", delivered - d0);
        end else begin
            n_checks++;
            if (hs_cyc[3] - hs_cyc[0] !== 3) begin
                n_fail++;
                $display("FAIL basic_throughput: got span %0d cycles for 4 pixels, required 3", hs_cyc[3] - hs_cyc[0]);
            end
        end
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_err: got ERR=%b, required 0", err);
        end
    endtask

    task automatic test_backpressure();
        int d0, rc, holds;
        apply_reset();
        enable = 1'b1; dout_ready = 1'b0;
        d0 = delivered; rc = 0; holds = 0;
        for (int i = 0; i < 18; i++) begin
            if (i < 10) begin
                push_en = 1'b1; push_data = pixel_t'(i + 1); exp_q.push_back(pixel_t'(i + 1));
            end else begin
                push_en = 1'b0;
            end
            @(negedge clk);
            if (read_en) rc++;
            if (dout_valid) begin
                holds++;
                n_checks++;
                if (dout !== 16'd1) begin
                    n_fail++;
                    $display("FAIL stall_hold: got DOUT=%h during stall, required 0001", dout);
                end
            end
            @(posedge clk); #1;
        end
        push_en = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rc !== 3) begin
            n_fail++;
            $display("FAIL stall_reads: got %0d READ_EN pulses, required 3", rc);
        end
        n_checks++;
        if (occupancy !== 2'd3 || holds == 0) begin
            n_fail++;
            $display("FAIL stall_occupancy: got OCCUPANCY=%0d (held %0d cycles), required 3", occupancy, holds);
        end
        @(posedge clk); #1 dout_ready = 1'b1;
        for (int c = 0; c < 60 && delivered - d0 < 10; c++) @(negedge clk);
        @(posedge clk); #1;
        n_checks++;
        if (delivered - d0 !== 10) begin
            n_fail++;
            $display("FAIL stall_drain: got %0d pixels, required 10", delivered - d0);
        end
    endtask

    task automatic test_end_of_line();
        int d0;
        apply_reset();
        enable = 1'b1; dout_ready = 1'b1;
        d0 = delivered;
        for (int v = 1; v <= 9; v++) push_word(pixel_t'(v));
        for (int c = 0; c < 40 && delivered - d0 < 9; c++) @(negedge clk);
        @(posedge clk); #1;
        n_checks++;
        if (eol_q.size() != 2) begin
            n_fail++;
            $display("FAIL eol_count: got %0d EOL pixels, required 2", eol_q.size());
        end else begin
            n_checks++;
            if (eol_q[0] !== 16'd4 || eol_q[1] !== 16'd8) begin
                n_fail++;
                $display("FAIL eol_pixels: got %0d,%0d, required 4,8", eol_q[0], eol_q[1]);
            end
        end
        n_checks++;
        if (col_q.size() != 9) begin
            n_fail++;
            $display("FAIL eol_drain: got %0d pixels, required 9", col_q.size());
        end else begin
            n_checks++;
            if (col_q[4] !== '0 || col_q[8] !== '0) begin
                n_fail++;
                $display("FAIL col_wrap: got col %0d,%0d on pixels 5,9, required 0,0", col_q[4], col_q[8]);
            end
        end
    endtask

    task automatic test_enable_gating();
        int d0;
        apply_reset();
        enable = 1'b0; dout_ready = 1'b1;
        d0 = delivered;
        for (int i = 0; i < 6; i++) push_word(pixel_t'($urandom));
        @(posedge clk); #1 enable = 1'b1;
        @(negedge clk);
        n_checks++;
        if (read_en !== 1'b1) begin
            n_fail++;
            $display("FAIL enable_first_read: got READ_EN=%b, required 1", read_en);
        end
        @(posedge clk); #1 enable = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_checks++;
            if (read_en !== 1'b0) begin
                n_fail++;
                $display("FAIL enable_gated: got READ_EN=%b with ENABLE=0, required 0", read_en);
            end
        end
        @(posedge clk); #1;
        n_checks++;
        if (delivered - d0 !== 1) begin
            n_fail++;
            $display("FAIL enable_single: got %0d pixels, required 1", delivered - d0);
        end
        enable = 1'b1;
        for (int c = 0; c < 40 && delivered - d0 < 6; c++) @(negedge clk);
        @(posedge clk); #1;
        n_checks++;
        if (delivered - d0 !== 6) begin
            n_fail++;
            $display("FAIL enable_resume: got %0d pixels, required 6", delivered - d0);
        end
    endtask

    task automatic test_reset_mid();
        logic prev_re, found;
        int   d0;
        apply_reset();
        enable = 1'b1; dout_ready = 1'b0;
        prev_re = 1'b0; found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (i < 5) begin
                push_en = 1'b1; push_data = pixel_t'($urandom); exp_q.push_back(push_data);
            end else begin
                push_en = 1'b0;
            end
            @(negedge clk);
            if (occupancy == 2'd2 && prev_re) begin
                found   = 1'b1;
                reset   = 1'b1;
                push_en = 1'b0;
                exp_q.delete();
                out_idx = 0;
            end else begin
                prev_re = read_en;
            end
            @(posedge clk); #1;
        end
        reset = 1'b0; push_en = 1'b0;
        n_checks++;
        if (found !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_setup: got found=%b, required OCCUPANCY=2 with a word in flight", found);
        end
        @(negedge clk);
        n_checks++;
        if ({dout_valid, occupancy, col_count, err} !== '0) begin
            n_fail++;
            $display("FAIL midreset_clear: got v=%b occ=%0d col=%0d err=%b, required all 0",
                     dout_valid, occupancy, col_count, err);
        end
        @(posedge clk); #1 dout_ready = 1'b1;
        d0 = delivered;
        push_word(16'd60);
        for (int c = 0; c < 20 && delivered == d0; c++) @(negedge clk);
        @(posedge clk); #1;
        n_checks++;
        if (delivered - d0 !== 1 || last_dout !== 16'd60 || last_col !== '0) begin
            n_fail++;
            $display("FAIL midreset_restart: got %0d pixels, last=%0d col=%0d, required 1 pixel 60 col 0",
                     delivered - d0, last_dout, last_col);
        end
    endtask

    task automatic test_error_latch();
        int d0;
        apply_reset();
        enable = 1'b1; dout_ready = 1'b1;
        d0 = delivered;
        push_word(16'd20);
        push_word(16'd30);
        push_en = 1'b1; push_data = 16'd40; exp_q.push_back(16'd40); rderr = 1'b1;
        @(negedge clk);
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_early: got ERR=%b before the edge, required 0", err);
        end
        @(posedge clk); #1 rderr = 1'b0; push_en = 1'b0;
        @(negedge clk);
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_set: got ERR=%b, required 1", err);
        end
        for (int c = 0; c < 20 && delivered - d0 < 3; c++) @(negedge clk);
        repeat (4) @(negedge clk);
        n_checks++;
        if (err !== 1'b1 || delivered - d0 !== 3) begin
            n_fail++;
            $display("FAIL err_sticky: got ERR=%b after %0d pixels, required ERR=1 and 3 pixels", err, delivered - d0);
        end
        @(posedge clk); #1;
        apply_reset();
        @(negedge clk);
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clear: got ERR=%b after reset, required 0", err);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random_stream();
        int d0, pushed;
        apply_reset();
        d0 = delivered; pushed = 0;
        for (int c = 0; c < 400; c++) begin
            push_en    = ($urandom_range(0, 1) == 1);
            push_data  = pixel_t'($urandom);
            enable     = ($urandom_range(0, 3) != 0);
            dout_ready = ($urandom_range(0, 1) == 1);
            if (push_en) begin
                exp_q.push_back(push_data);
                pushed++;
            end
            @(posedge clk); #1;
        end
        push_en = 1'b0; enable = 1'b1; dout_ready = 1'b1;
        for (int c = 0; c < 600 && exp_q.size() != 0; c++) @(negedge clk);
        repeat (3) @(negedge clk);
        n_checks++;
        if (delivered - d0 !== pushed || occupancy !== 2'd0) begin
            n_fail++;
            $display("FAIL random_drain: got %0d pixels occ=%0d, required %0d pixels occ=0",
                     delivered - d0, occupancy, pushed);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; rderr = 1'b0; dout_ready = 1'b0;
        push_en = 1'b0; push_data = '0;
        test_reset();
        test_basic_drain();
        test_backpressure();
        test_end_of_line();
        test_enable_gating();
        test_reset_mid();
        test_error_latch();
        test_random_stream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
